// File: rtl/sp_mul_if.sv
// rtl/sp_mul_if.sv - operand/result handshake bundle between filter sequencer and sp_mul
interface sp_mul_if;
  logic [15:0] sig_in;
  logic [9:0]  coef_in;
  logic        start;
  logic [15:0] result_out;
  logic        done;

  modport master (
    output sig_in,
    output coef_in,
    output start,
    input  result_out,
    input  done
  );

  modport slave (
    input  sig_in,
    input  coef_in,
    input  start,
    output result_out,
    output done
  );
endinterface

// File: rtl/sp_mul.sv
// rtl/sp_mul.sv - serial/parallel 16b signal x 10b sign-magnitude coefficient multiplier
// One coefficient bit per clock, LSB first, through a single shift-add accumulator.
module sp_mul (
  input  logic    clk,
  input  logic    rst_an,
  sp_mul_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_finish;

  logic signed [15:0] r_sig;
  logic [8:0]         r_mag;
  logic               r_sign;
  logic signed [16:0] r_acc;
  logic [3:0]         r_cnt;
  logic [15:0]        r_result;

  logic signed [17:0] w_addend;
  logic signed [17:0] w_sum;
  logic [15:0]        w_res;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_step = 1'b1;
        if (r_cnt == 4'd8) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Halving after every add keeps the floor exact: nested floors of /2 equal one floor of /512.
  assign w_addend = r_mag[0] ? 18'(r_sig) : 18'sd0;
  assign w_sum    = 18'(r_acc) + w_addend;

  // |P| <= 32704, so the negated value always fits the 16-bit result.
  assign w_res = 16'(r_sign ? -r_acc : r_acc);

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_sig    <= '0;
      r_mag    <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_sig  <= bus.sig_in;
        r_mag  <= bus.coef_in[8:0];
        r_sign <= bus.coef_in[9];
        r_acc  <= '0;
        r_cnt  <= '0;
      end
      if (w_step) begin
        r_acc <= 17'(w_sum >>> 1);
        r_mag <= r_mag >> 1;
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_finish) begin
        r_result <= w_res;
      end
    end
  end

  assign bus.done       = (r_state == S_IDLE);
  assign bus.result_out = r_result;

endmodule

// File: tb/tb_sp_mul.sv
// tb/tb_sp_mul.sv - directed table, operand-capture, abort and random checks for sp_mul
module tb_sp_mul;

  logic clk    = 1'b0;
  logic rst_an = 1'b1;

  sp_mul_if bus ();

  sp_mul u_dut (
    .clk    (clk),
    .rst_an (rst_an),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] sig;
    logic [9:0]  coef;
    logic [15:0] expect_res;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Product straight from the arithmetic definition: floor(sig*mag/512), then sign.
  function automatic logic [15:0] ref_mul(input logic [15:0] s, input logic [9:0] c);
    int si;
    int mag;
    int p;
    si  = $signed(s);
    mag = int'(c[8:0]);
    p   = si * mag;
    p   = p >>> 9;
    if (c[9]) p = -p;
    return p[15:0];
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge where done rose (or the bound expired).
  task automatic do_mul(input logic [15:0] s, input logic [9:0] c, input logic [15:0] exp_res,
                        input string nm, input bit poke);
    logic [15:0] prev;
    int          lat;
    bit          stable;
    prev   = bus.result_out;
    lat    = 0;
    stable = 1'b1;
    bus.sig_in  = s;
    bus.coef_in = c;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.sig_in  = 16'($urandom);
    bus.coef_in = 10'($urandom);
    chk({nm, "/done_low"}, 32'(bus.done), 32'd0);
    while (!bus.done && lat < 20) begin
      if (poke && lat == 3) begin
        bus.start   = 1'b1;
        bus.sig_in  = 16'($urandom);
        bus.coef_in = 10'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!bus.done && bus.result_out !== prev) stable = 1'b0;
    end
    bus.start = 1'b0;
    chk({nm, "/latency"}, 32'(lat), 32'd10);
    chk({nm, "/result"}, 32'(bus.result_out), 32'(exp_res));
    chk({nm, "/held_busy"}, 32'(stable), 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'd16384,          10'h100, 16'd8192,           "pos_half"};
    vecs[1] = '{16'(-16'sd16384),   10'h300, 16'd8192,           "neg_neg"};
    vecs[2] = '{16'd1000,           10'h1FF, 16'd998,            "trunc_511"};
    vecs[3] = '{16'hFFFF,           10'h001, 16'hFFFF,           "floor_neg"};
    vecs[4] = '{16'hFFFF,           10'h201, 16'd1,              "floor_negate"};
    vecs[5] = '{16'h8000,           10'h1FF, 16'(-16'sd32704),   "min_pos"};
    vecs[6] = '{16'h8000,           10'h3FF, 16'd32704,          "min_neg"};
    vecs[7] = '{16'd32767,          10'h000, 16'd0,              "zero_coef"};
    vecs[8] = '{16'd32767,          10'h200, 16'd0,              "neg_zero_coef"};

    bus.sig_in  = '0;
    bus.coef_in = '0;
    bus.start   = 1'b0;

    #1 rst_an = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/done", 32'(bus.done), 32'd1);
    chk("reset/result", 32'(bus.result_out), 32'd0);
    @(negedge clk);
    rst_an = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_mul(vecs[i].sig, vecs[i].coef, vecs[i].expect_res, vecs[i].name, 1'b0);
    end

    // Back-to-back with a second start pulse while busy: captured operands must win.
    do_mul(16'd1000, 10'h1FF, 16'd998, "capture_a", 1'b1);
    do_mul(16'hFFFF, 10'h201, 16'd1,   "capture_b", 1'b1);

    // Abort mid-product after a non-zero result is on the output.
    do_mul(16'd16384, 10'h100, 16'd8192, "pre_abort", 1'b0);
    bus.sig_in  = 16'd20000;
    bus.coef_in = 10'h0FF;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_an = 1'b0;
    #1;
    chk("abort/done", 32'(bus.done), 32'd1);
    chk("abort/result", 32'(bus.result_out), 32'd0);
    @(posedge clk); #1;
    rst_an = 1'b1;
    @(posedge clk); #1;
    do_mul(16'd20000, 10'h0FF, ref_mul(16'd20000, 10'h0FF), "after_abort", 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] s;
      logic [9:0]  c;
      int          gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 7))
        0:       s = 16'h8000;
        1:       s = 16'h7FFF;
        2:       s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      c = ($urandom_range(0, 7) == 0) ? {1'($urandom), 9'h1FF} : 10'($urandom);
      do_mul(s, c, ref_mul(s, c), $sformatf("rand%0d", n), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
